// File: rtl/dual_core_mem_arbiter_if.sv
// dual_core_mem_arbiter_if: bundles the two core data ports, the shared
// memory port and the per-core grant counters of the dual-core arbiter.
// Core 1 occupies bit 0 / the low slice of every per-core field, core 2
// occupies bit 1 / the high slice.
interface dual_core_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Core data ports (req/gnt/rvalid handshake)
    logic [1:0]              core_req_i;
    logic [2*ADDR_WIDTH-1:0] core_addr_i;
    logic [1:0]              core_we_i;
    logic [2*BE_WIDTH-1:0]   core_be_i;
    logic [2*DATA_WIDTH-1:0] core_wdata_i;
    logic [1:0]              core_gnt_o;
    logic [1:0]              core_rvalid_o;
    logic [DATA_WIDTH-1:0]   core_rdata_o;
    logic [1:0]              core_err_o;

    // Shared single-port memory
    logic                    mem_req_o;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic                    mem_we_o;
    logic [BE_WIDTH-1:0]     mem_be_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic                    mem_gnt_i;
    logic                    mem_rvalid_i;
    logic [DATA_WIDTH-1:0]   mem_rdata_i;
    logic                    mem_err_i;

    // Debug / monitoring
    logic [2*CNT_WIDTH-1:0]  grant_cnt_o;

    // Arbiter side
    modport slave (
        input  core_req_i, core_addr_i, core_we_i, core_be_i, core_wdata_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output grant_cnt_o
    );

    // Environment side (cores + memory)
    modport master (
        output core_req_i, core_addr_i, core_we_i, core_be_i, core_wdata_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  grant_cnt_o
    );
endinterface

// File: rtl/dual_core_mem_arbiter.sv
// dual_core_mem_arbiter: round-robin arbiter sharing one single-port data
// memory between two cores. One transaction in flight at a time; the
// response is routed back to the core that was granted. Grant and response
// paths are combinational (zero latency) from the memory handshake.
module dual_core_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    dual_core_mem_arbiter_if.slave  bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Core indices: 1'b0 = core 1, 1'b1 = core 2
    state_t               state_q, state_d;
    logic                 sel_q, sel_d;
    logic                 last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt_q [2];

    logic                 winner;
    logic                 route;
    logic                 req_int;
    logic [1:0]           gnt_int;
    logic [1:0]           rvalid_int;
    logic [1:0]           err_int;

    // Per-core views of the packed request fields
    logic [ADDR_WIDTH-1:0] addr_c  [2];
    logic                  we_c    [2];
    logic [BE_WIDTH-1:0]   be_c    [2];
    logic [DATA_WIDTH-1:0] wdata_c [2];

    assign addr_c[0]  = bus.core_addr_i[ADDR_WIDTH-1:0];
    assign addr_c[1]  = bus.core_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign we_c[0]    = bus.core_we_i[0];
    assign we_c[1]    = bus.core_we_i[1];
    assign be_c[0]    = bus.core_be_i[BE_WIDTH-1:0];
    assign be_c[1]    = bus.core_be_i[2*BE_WIDTH-1:BE_WIDTH];
    assign wdata_c[0] = bus.core_wdata_i[DATA_WIDTH-1:0];
    assign wdata_c[1] = bus.core_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH];

    // Round-robin pick: on a tie the core that was not granted last wins
    always_comb begin
        winner = sel_q;
        case (bus.core_req_i)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_q;
            default: winner = sel_q;
        endcase
    end

    // Next-state and handshake decode; selection is frozen once it leaves IDLE
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        route      = sel_q;
        req_int    = 1'b0;
        gnt_int    = 2'b00;
        rvalid_int = 2'b00;
        err_int    = 2'b00;
        case (state_q)
            IDLE: begin
                if (|bus.core_req_i) begin
                    route   = winner;
                    req_int = 1'b1;
                    sel_d   = winner;
                    if (bus.mem_gnt_i) begin
                        gnt_int[winner] = 1'b1;
                        last_d          = winner;
                        state_d         = WAIT;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                req_int = 1'b1;
                if (bus.mem_gnt_i) begin
                    gnt_int[sel_q] = 1'b1;
                    last_d         = sel_q;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid_i) begin
                    rvalid_int[sel_q] = 1'b1;
                    err_int[sel_q]    = bus.mem_err_i;
                    state_d           = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output drive; everything is held at zero while reset is asserted
    always_comb begin
        bus.mem_req_o     = rst_ni & req_int;
        bus.mem_addr_o    = rst_ni ? addr_c[route]  : '0;
        bus.mem_we_o      = rst_ni & we_c[route];
        bus.mem_be_o      = rst_ni ? be_c[route]    : '0;
        bus.mem_wdata_o   = rst_ni ? wdata_c[route] : '0;
        bus.core_gnt_o    = rst_ni ? gnt_int        : 2'b00;
        bus.core_rvalid_o = rst_ni ? rvalid_int     : 2'b00;
        bus.core_err_o    = rst_ni ? err_int        : 2'b00;
        bus.core_rdata_o  = rst_ni ? bus.mem_rdata_i : '0;
        bus.grant_cnt_o   = {cnt_q[1], cnt_q[0]};
    end

    // Control state; reset leaves last = core 2 so core 1 wins the first tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Per-core grant counters, wrapping modulo 2^CNT_WIDTH
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(gnt_int[i]);
            end
        end
    end
endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// tb_dual_core_mem_arbiter: directed scenarios followed by a randomized
// run checked through grant/response scoreboards fed by a transaction-level
// model of the arbitration rules.
module tb_dual_core_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dual_core_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    dual_core_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        int          cyc;
        int          core;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gnt_exp_t;

    typedef struct {
        int          cyc;
        int          core;
        logic [31:0] data;
        logic        err;
    } rsp_exp_t;

    gnt_exp_t gnt_q[$];
    rsp_exp_t rsp_q[$];
    gnt_exp_t ge;
    rsp_exp_t re;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit sb_on   = 1'b0;

    // Core-side request state (what each core is currently presenting)
    bit          pend    [2];
    logic [31:0] c_addr  [2];
    logic        c_we    [2];
    logic [3:0]  c_be    [2];
    logic [31:0] c_wdata [2];

    // Reference model: transaction-level view of the arbiter
    int chosen;      // core picked but not yet granted, -1 = none
    int busy;        // core whose granted access awaits its response, -1 = none
    int last;        // core granted most recently
    int rsp_delay;   // cycles left before the memory answers
    int m_cnt [2];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_cores();
        bus.core_req_i   = {pend[1], pend[0]};
        bus.core_addr_i  = {c_addr[1], c_addr[0]};
        bus.core_we_i    = {c_we[1], c_we[0]};
        bus.core_be_i    = {c_be[1], c_be[0]};
        bus.core_wdata_i = {c_wdata[1], c_wdata[0]};
    endtask

    task automatic set_core(input int c, input logic [31:0] a, input logic w,
                            input logic [3:0] b, input logic [31:0] d);
        pend[c]    = 1'b1;
        c_addr[c]  = a;
        c_we[c]    = w;
        c_be[c]    = b;
        c_wdata[c] = d;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            pend[c] = 1'b0; c_addr[c] = '0; c_we[c] = 1'b0; c_be[c] = '0; c_wdata[c] = '0;
            m_cnt[c] = 0;
        end
        drive_cores();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0; bus.mem_err_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chosen = -1; busy = -1; last = 1; rsp_delay = 0;
    endtask

    // One randomized cycle: cores, memory and the reference model advance together
    task automatic rand_cycle(input bit allow_new);
        bit freed;
        step();
        freed = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_err_i    = 1'($urandom_range(0, 1));
        bus.mem_rdata_i  = $urandom;
        for (int c = 0; c < 2; c++) begin
            if (!pend[c] && allow_new && $urandom_range(0, 2) != 0)
                set_core(c, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end
        drive_cores();
        if (busy >= 0) begin
            if (rsp_delay == 0) begin
                bus.mem_rvalid_i = 1'b1;
                rsp_q.push_back('{cyc, busy, bus.mem_rdata_i, bus.mem_err_i});
                busy  = -1;
                freed = 1'b1;
            end else begin
                rsp_delay--;
            end
        end else if ($urandom_range(0, 9) == 0) begin
            bus.mem_rvalid_i = 1'b1;  // stray response while nothing is outstanding
        end
        if (busy < 0 && !freed) begin
            if (chosen < 0 && (pend[0] || pend[1]))
                chosen = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
            if (chosen >= 0 && $urandom_range(0, 1) == 1) begin
                bus.mem_gnt_i = 1'b1;
                gnt_q.push_back('{cyc, chosen, c_addr[chosen], c_we[chosen], c_be[chosen], c_wdata[chosen]});
                last = chosen;
                m_cnt[chosen]++;
                busy = chosen;
                pend[chosen] = 1'b0;
                rsp_delay = $urandom_range(0, 3);
                chosen = -1;
            end
        end
    endtask

    // Monitor: pops an expectation whenever the DUT signals, or when one falls due
    always @(negedge clk) begin
        if (sb_on) begin
            if (bus.core_gnt_o != 2'b00 || (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc)) begin
                if (gnt_q.size() == 0) begin
                    check("gnt_unexpected", 64'(bus.core_gnt_o), 64'd0);
                end else begin
                    ge = gnt_q.pop_front();
                    check("gnt_core", 64'(bus.core_gnt_o), (ge.core == 0) ? 64'd1 : 64'd2);
                    check("gnt_cycle", 64'(cyc), 64'(ge.cyc));
                    check("gnt_addr", 64'(bus.mem_addr_o), 64'(ge.addr));
                    check("gnt_we", 64'(bus.mem_we_o), 64'(ge.we));
                    check("gnt_be", 64'(bus.mem_be_o), 64'(ge.be));
                    check("gnt_wdata", 64'(bus.mem_wdata_o), 64'(ge.wdata));
                end
            end
            if (bus.core_rvalid_o != 2'b00 || (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc)) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.core_rvalid_o), 64'd0);
                end else begin
                    re = rsp_q.pop_front();
                    check("rsp_core", 64'(bus.core_rvalid_o), (re.core == 0) ? 64'd1 : 64'd2);
                    check("rsp_cycle", 64'(cyc), 64'(re.cyc));
                    check("rsp_rdata", 64'(bus.core_rdata_o), 64'(re.data));
                    check("rsp_err", 64'(bus.core_err_o),
                          re.err ? ((re.core == 0) ? 64'd1 : 64'd2) : 64'd0);
                end
            end
        end
    end

    initial begin
        // Single core read, single-cycle memory
        do_reset();
        @(negedge clk);
        check("rst_cnt", 64'(bus.grant_cnt_o), 64'd0);
        check("rst_mreq", 64'(bus.mem_req_o), 64'd0);
        step();
        set_core(0, 32'h100, 1'b0, 4'hF, 32'h0); drive_cores();
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        check("t1_gnt", 64'(bus.core_gnt_o), 64'd1);
        check("t1_mreq", 64'(bus.mem_req_o), 64'd1);
        check("t1_maddr", 64'(bus.mem_addr_o), 64'h100);
        step();
        pend[0] = 1'b0; drive_cores();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_rvalid", 64'(bus.core_rvalid_o), 64'd1);
        check("t1_rdata", 64'(bus.core_rdata_o), 64'hDEADBEEF);
        step();
        bus.mem_rvalid_i = 1'b0;
        @(negedge clk);
        check("t1_cnt", 64'(bus.grant_cnt_o), 64'h0000_0001);

        // Contention from reset, memory always granting
        do_reset();
        step();
        set_core(0, 32'h200, 1'b0, 4'hF, 32'h0);
        set_core(1, 32'h300, 1'b0, 4'hF, 32'h0);
        drive_cores();
        bus.mem_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.mem_rvalid_i = 1'b0;
            @(negedge clk);
            check("t2_gnt", 64'(bus.core_gnt_o), (k % 2 == 0) ? 64'd1 : 64'd2);
            check("t2_maddr", 64'(bus.mem_addr_o), (k % 2 == 0) ? 64'h200 : 64'h300);
            step();
            bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'(k);
            @(negedge clk);
            check("t2_wait_gnt", 64'(bus.core_gnt_o), 64'd0);
            check("t2_rvalid", 64'(bus.core_rvalid_o), (k % 2 == 0) ? 64'd1 : 64'd2);
            step();
        end
        bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b0;
        @(negedge clk);
        check("t2_cnt", 64'(bus.grant_cnt_o), 64'h0002_0002);

        // Delayed grant: selection stays on core 2 while core 1 joins
        do_reset();
        step();
        set_core(1, 32'hB000, 1'b0, 4'hF, 32'h0); drive_cores();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin set_core(0, 32'hA000, 1'b0, 4'hF, 32'h0); drive_cores(); end
            bus.mem_gnt_i = (k == 3);
            @(negedge clk);
            check("t3_maddr", 64'(bus.mem_addr_o), 64'hB000);
            check("t3_gnt", 64'(bus.core_gnt_o), (k == 3) ? 64'd2 : 64'd0);
            step();
        end
        pend[1] = 1'b0; drive_cores();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
        @(negedge clk);
        check("t3_rvalid", 64'(bus.core_rvalid_o), 64'd2);
        step();
        bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        check("t3_gnt_next", 64'(bus.core_gnt_o), 64'd1);
        step();
        pend[0] = 1'b0; drive_cores();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
        step();
        bus.mem_rvalid_i = 1'b0;

        // Write with error response, then a stray rvalid in IDLE
        do_reset();
        step();
        set_core(0, 32'h40, 1'b1, 4'b0011, 32'h12345678); drive_cores();
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        check("t4_we", 64'(bus.mem_we_o), 64'd1);
        check("t4_be", 64'(bus.mem_be_o), 64'h3);
        check("t4_wdata", 64'(bus.mem_wdata_o), 64'h12345678);
        step();
        pend[0] = 1'b0; c_we[0] = 1'b0; drive_cores();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_err_i = 1'b1;
        @(negedge clk);
        check("t4_rvalid", 64'(bus.core_rvalid_o), 64'd1);
        check("t4_err", 64'(bus.core_err_o), 64'd1);
        step();
        bus.mem_err_i = 1'b1;  // rvalid stays high but the arbiter is idle now
        @(negedge clk);
        check("t5_rvalid", 64'(bus.core_rvalid_o), 64'd0);
        check("t5_err", 64'(bus.core_err_o), 64'd0);
        step();
        bus.mem_rvalid_i = 1'b0; bus.mem_err_i = 1'b0;
        set_core(1, 32'h80, 1'b0, 4'hF, 32'h0); drive_cores();
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        check("t5_gnt_idle", 64'(bus.core_gnt_o), 64'd2);
        step();
        pend[1] = 1'b0; drive_cores();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
        step();
        bus.mem_rvalid_i = 1'b0;

        // Reset while waiting for the response
        do_reset();
        step();
        set_core(0, 32'h500, 1'b0, 4'hF, 32'h0); drive_cores();
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        check("t6_gnt", 64'(bus.core_gnt_o), 64'd1);
        step();
        set_core(1, 32'h600, 1'b0, 4'hF, 32'h0); drive_cores();
        bus.mem_rvalid_i = 1'b1; bus.mem_err_i = 1'b1; bus.mem_rdata_i = 32'hCAFE0000;
        rst_n = 1'b0;
        #1;
        check("t6_rst_mreq", 64'(bus.mem_req_o), 64'd0);
        check("t6_rst_gnt", 64'(bus.core_gnt_o), 64'd0);
        check("t6_rst_rvalid", 64'(bus.core_rvalid_o), 64'd0);
        check("t6_rst_err", 64'(bus.core_err_o), 64'd0);
        check("t6_rst_cnt", 64'(bus.grant_cnt_o), 64'd0);
        check("t6_rst_maddr", 64'(bus.mem_addr_o), 64'd0);
        step();
        step();
        rst_n = 1'b1; bus.mem_rvalid_i = 1'b0; bus.mem_err_i = 1'b0;
        @(negedge clk);
        check("t6_cnt_zero", 64'(bus.grant_cnt_o), 64'd0);
        check("t6_tie_gnt", 64'(bus.core_gnt_o), 64'd1);
        step();
        pend[0] = 1'b0; pend[1] = 1'b0; drive_cores(); bus.mem_gnt_i = 1'b0;
        @(negedge clk);
        check("t6_cnt_after", 64'(bus.grant_cnt_o), 64'h0000_0001);

        // Randomized traffic against the scoreboards
        do_reset();
        sb_on = 1'b1;
        repeat (3000) rand_cycle(1'b1);
        for (int i = 0; i < 200 && (pend[0] || pend[1] || chosen >= 0 || busy >= 0); i++)
            rand_cycle(1'b0);
        check("drain_done", 64'((pend[0] || pend[1] || chosen >= 0 || busy >= 0) ? 1 : 0), 64'd0);
        step();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        @(negedge clk);
        #1;
        sb_on = 1'b0;
        check("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
        check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        check("rand_cnt_core1", 64'(bus.grant_cnt_o[CW-1:0]), 64'(m_cnt[0] & 32'hFFFF));
        check("rand_cnt_core2", 64'(bus.grant_cnt_o[2*CW-1:CW]), 64'(m_cnt[1] & 32'hFFFF));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
